// File: rtl/digit_serial_adder.sv
// Digit-serial adder/subtractor: one DIGIT-wide ripple slice reused K = WIDTH/DIGIT
// times, LSB digit first, with a start/busy/done handshake and held registered results.
module digit_serial_adder #(
    parameter int WIDTH = 16,
    parameter int DIGIT = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             zero
);

    localparam int K  = WIDTH / DIGIT;
    localparam int CW = (K > 1) ? $clog2(K) : 1;

    typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

    state_t           state;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] res_sh;
    logic             carry;
    logic [CW-1:0]    cnt;

    logic [DIGIT:0]   slice;
    logic             carry_msb;
    logic [WIDTH-1:0] res_next;
    logic             last;

    always_comb begin
        slice     = {1'b0, a_sh[DIGIT-1:0]} + {1'b0, b_sh[DIGIT-1:0]} + (DIGIT+1)'(carry);
        // Carry into the top bit of this digit, recovered from its sum bit; on the
        // final digit this is the carry into the operand MSB.
        carry_msb = slice[DIGIT-1] ^ a_sh[DIGIT-1] ^ b_sh[DIGIT-1];
        res_next  = (res_sh >> DIGIT) | (WIDTH'(slice[DIGIT-1:0]) << (WIDTH - DIGIT));
        last      = (cnt == CW'(K - 1));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            a_sh   <= '0;
            b_sh   <= '0;
            res_sh <= '0;
            carry  <= 1'b0;
            cnt    <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
            sum    <= '0;
            cout   <= 1'b0;
            ovf    <= 1'b0;
            zero   <= 1'b1;
        end else begin
            case (state)
                IDLE, FIN: begin
                    done <= 1'b0;
                    if (start) begin
                        a_sh  <= a;
                        b_sh  <= sub ? ~b : b;
                        carry <= sub ? 1'b1 : cin;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= RUN;
                    end else begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                RUN: begin
                    a_sh   <= a_sh >> DIGIT;
                    b_sh   <= b_sh >> DIGIT;
                    res_sh <= res_next;
                    carry  <= slice[DIGIT];
                    cnt    <= cnt + CW'(1);
                    if (last) begin
                        state <= FIN;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        sum   <= res_next;
                        cout  <= slice[DIGIT];
                        ovf   <= slice[DIGIT] ^ carry_msb;
                        zero  <= (res_next == '0);
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/digit_serial_adder.md
# digit_serial_adder

Multi-cycle, parametrised successor to the single-bit full adder: adds (or subtracts) two WIDTH-bit operands DIGIT bits per clock, LSB digit first, reusing one DIGIT-wide ripple slice and a registered carry. It serves area-constrained datapaths in the CPU, such as the address/offset unit and the multi-cycle ALU path, where a full-width adder is not justified. A start/busy/done handshake controls it; results are registered and held until the next accepted operation.

## Interface
- WIDTH, 16, operand/result width; must be a positive multiple of DIGIT
- DIGIT, 4, bits processed per cycle; 1 ≤ DIGIT ≤ WIDTH
- clk  in  1  single clock; all state updates on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- start  in  1  request; sampled only when busy=0
- sub  in  1  mode: 0 = a + b + cin, 1 = a + ~b + 1 (cin ignored)
- a  in  WIDTH  operand A, latched on accept
- b  in  WIDTH  operand B, latched on accept
- cin  in  1  carry-in for add mode, latched on accept
- busy  out  1  operation in progress
- done  out  1  one-cycle pulse: results updated this cycle
- sum  out  WIDTH  registered result
- cout  out  1  carry out of MSB (sub mode: 1 = no borrow)
- ovf  out  1  signed overflow: carry into MSB XOR carry out of MSB
- zero  out  1  sum == 0

## Operation
- K = WIDTH/DIGIT digit steps per operation.
- States: IDLE, RUN, FIN.
- IDLE: busy=0. start=1 at an edge causes accept: latch a, (sub ? ~b : b), carry = (sub ? 1 : cin), clear digit counter, go to RUN.
- RUN: busy=1. Each edge adds the low DIGIT bits of the A/B shift registers plus the carry register. It shifts the DIGIT-bit result into the internal result shift register from the MSB side, shifts A/B right by DIGIT, updates carry, and increments the counter. On the K-th RUN edge it captures carry into MSB for ovf and goes to FIN, copying the assembled result to sum and setting cout, ovf, and zero.
- FIN: done=1, busy=0 for exactly one cycle, then IDLE. start=1 in FIN is accepted exactly as in IDLE (back-to-back).
- start while busy=1 is ignored; no queuing.
- sum, cout, ovf, and zero change only on the edge entering FIN. They hold their previous values during RUN and indefinitely while idle.
- All arithmetic is modulo 2^WIDTH; no saturation.
- DIGIT = WIDTH is legal: K=1, one RUN cycle.

## Timing
- Reset (rst_n=0, asynchronous): state=IDLE, busy=0, done=0, sum=0, cout=0, ovf=0, zero=1, counter/carry/shift registers cleared.
- Reset mid-operation aborts the operation: no done pulse, outputs take their reset values immediately.
- Accept edge E0 → busy=1 after E0. Digit edges are E1..EK. done=1 and results valid after EK, so latency is K+1 edges from accept to done deasserting.
- Throughput with back-to-back starts is one result per K+1 cycles.
- Inputs a, b, cin, and sub may change freely after the accept edge.
- Release of rst_n is synchronous to clk in the system; no start is asserted in the release cycle.

## Test plan
- Reset: assert rst_n=0 mid-RUN of any operation → busy=0, done=0, sum=0x0000, cout=0, ovf=0, zero=1 immediately. No later done pulse.
- WIDTH=16, DIGIT=4, add: a=0x1234, b=0x0FCD, cin=0 → done 4 cycles after accept, sum=0x2201, cout=0, ovf=0, zero=0. a=0xFFFF, b=0x0001 → sum=0x0000, cout=1, ovf=0, zero=1.
- Signed overflow: a=0x7FFF, b=0x0001, cin=0 → sum=0x8000, ovf=1, cout=0. Same operands with cin=1 → sum=0x8001, ovf=1.
- Subtract: sub=1, a=0x0005, b=0x0007, cin=1 (ignored) → sum=0xFFFE, cout=0, ovf=0. a=0x8000, b=0x0001 → sum=0x7FFF, cout=1, ovf=1.
- Handshake: start held high continuously with changing operands → accepts only in IDLE/FIN cycles. done pulses every 5 cycles, each result matching the operands present on its accept edge. sum is stable between done pulses.
- Alternate configurations WIDTH=8, DIGIT=1 and WIDTH=8, DIGIT=8, run over all 2^17 combinations of (a, b, cin) plus a random sub sample → results match the reference model a+b+cin / a-b. Latency is 9 and 2 cycles respectively.
